// File: rtl/ctech_lib_sync_handshake_ctl_if.sv
// rtl/ctech_lib_sync_handshake_ctl_if.sv - source/transfer/ack signal bundle for the toggle handshake controller
interface ctech_lib_sync_handshake_ctl_if #(
   parameter int WIDTH = 8
);
   logic             src_valid;
   logic [WIDTH-1:0] src_data;
   logic             src_ready;
   logic [WIDTH-1:0] xfer_data;
   logic             xfer_req;
   logic             ack_async;
   logic             xfer_done;
   logic             timeout;
   logic             err;
   logic             clr_err;
   logic             busy;

   modport slave (
      input  src_valid, src_data, ack_async, clr_err,
      output src_ready, xfer_data, xfer_req, xfer_done, timeout, err, busy
   );

   modport master (
      output src_valid, src_data, ack_async, clr_err,
      input  src_ready, xfer_data, xfer_req, xfer_done, timeout, err, busy
   );
endinterface

// File: rtl/ctech_lib_sync_handshake_ctl.sv
// rtl/ctech_lib_sync_handshake_ctl.sv - source-side toggle req/ack controller for a multi-bit clock-domain crossing
module ctech_lib_sync_handshake_ctl #(
   parameter int WIDTH          = 8,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic                           clk,
   input  logic                           rstb,
   ctech_lib_sync_handshake_ctl_if.slave  bus
);

   localparam bit HAS_GAP = (GAP_CYCLES != 0);
   localparam bit HAS_TO  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] GAP_LAST = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] TO_LAST  = HAS_TO ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam longint MAX_CNT  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam bit     CNT_FITS = (MAX_CNT < (longint'(1) << CNT_W));

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_GAP,
      S_ERR
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             req_q, req_d;
   logic             done_q, done_d;
   logic             tmo_q, tmo_d;
   logic             err_q, err_d;
   logic [2:0]       ack_sync_q;
   logic             ack_sync;

   // Three flops because ack_async comes straight from the destination clock domain.
   assign ack_sync = ack_sync_q[2];

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         data_q     <= '0;
         req_q      <= 1'b0;
         done_q     <= 1'b0;
         tmo_q      <= 1'b0;
         err_q      <= 1'b0;
         ack_sync_q <= 3'b000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         req_q      <= req_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         ack_sync_q <= {ack_sync_q[1:0], bus.ack_async};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      req_d   = req_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.src_valid) begin
               data_d  = bus.src_data;
               req_d   = ~req_q;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A matching ack wins over an expiring timeout in the same cycle.
            if (ack_sync == req_q) begin
               done_d = 1'b1;
               if (HAS_GAP) begin
                  cnt_d   = GAP_LAST;
                  state_d = S_GAP;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (HAS_TO && (cnt_q == TO_LAST)) begin
               tmo_d   = 1'b1;
               err_d   = 1'b1;
               state_d = S_ERR;
            end else if (HAS_TO) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_ERR: begin
            // Retry re-enters WAIT without a new toggle; the held req is still outstanding.
            if (bus.clr_err) begin
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.src_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.xfer_data = data_q;
   assign bus.xfer_req  = req_q;
   assign bus.xfer_done = done_q;
   assign bus.timeout   = tmo_q;
   assign bus.err       = err_q;

   cnt_w_fits_a: assert property (@(posedge clk) CNT_FITS);

endmodule
